// File: rtl/dual_addr_regmem_if.sv
// dual_addr_regmem_if: bus bundle for dual_addr_regmem.
//   we     write enable, active-high (master -> slave)
//   waddr  write address             (master -> slave)
//   addr   read address              (master -> slave)
//   din    write data                (master -> slave)
//   dout   read data for addr        (slave -> master)
interface dual_addr_regmem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    modport master (output we, waddr, addr, din, input dout);
    modport slave  (input we, waddr, addr, din, output dout);
endinterface

// File: rtl/dual_addr_regmem.sv
// dual_addr_regmem: 2^ADDR_W x DATA_W register file with independent write and read addresses.
//   clk    rising-edge clock
//   reset  synchronous active-low reset; loads mem[i] = i
//   bus    dual_addr_regmem_if.slave (we, waddr, addr, din in; dout out)
// Optional macro DUAL_ADDR_REGMEM_OUT_REG_EN: registered dout (one-cycle read
// latency, cleared on reset); otherwise dout is a combinational read of mem[addr].
module dual_addr_regmem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input logic               clk,
    input logic               reset,
    dual_addr_regmem_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Reset wins over a write presented on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= DATA_W'(i);
        end else if (bus.we) begin
            r_mem[bus.waddr] <= bus.din;
        end
    end

`ifdef DUAL_ADDR_REGMEM_OUT_REG_EN
    logic [DATA_W-1:0] r_dout;

    // Samples mem before this edge's write, so a same-address write shows one edge later.
    always_ff @(posedge clk) begin
        if (!reset) r_dout <= '0;
        else        r_dout <= r_mem[bus.addr];
    end

    assign bus.dout = r_dout;
`else
    assign bus.dout = r_mem[bus.addr];
`endif
endmodule

// File: tb/tb_dual_addr_regmem.sv
// tb_dual_addr_regmem: directed plus random stimulus against an array model of the register file.
module tb_dual_addr_regmem;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   passed = 0;

    dual_addr_regmem_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    dual_addr_regmem #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] m [8];
    logic [15:0] exp_q = '0;
    bit          mvalid = 1'b0;

    // Model: reset pattern, then plain array writes; exp_q is the pre-write read for the registered build.
    always @(posedge clk) begin
        if (!reset) begin
            exp_q = 16'h0000;
            for (int i = 0; i < 8; i++) m[i] = 16'(i);
            mvalid = 1'b1;
        end else begin
            exp_q = m[bus.addr];
            if (bus.we) m[bus.waddr] = bus.din;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: dout=%h expected=%h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
`ifdef DUAL_ADDR_REGMEM_OUT_REG_EN
            check("model", bus.dout, exp_q);
`else
            check("model", bus.dout, m[bus.addr]);
`endif
        end
    end

    task automatic cyc(input logic r, input logic w, input logic [2:0] wa,
                       input logic [2:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        reset     = r;
        bus.we    = w;
        bus.waddr = wa;
        bus.addr  = a;
        bus.din   = d;
        @(negedge clk);
        #1;
    endtask

    // Read with no write; the registered build needs one extra edge with addr held.
    task automatic rd(input string name, input logic [2:0] a, input logic [15:0] exp);
        cyc(1'b1, 1'b0, 3'd0, a, 16'h0000);
`ifdef DUAL_ADDR_REGMEM_OUT_REG_EN
        cyc(1'b1, 1'b0, 3'd0, a, 16'h0000);
`endif
        check(name, bus.dout, exp);
    endtask

    initial begin
        bus.we = 1'b0;
        bus.waddr = '0;
        bus.addr = '0;
        bus.din = '0;
        cyc(1'b0, 1'b0, 3'd0, 3'd0, 16'h0000);
        for (int a = 0; a < 8; a++) rd("reset_contents", 3'(a), 16'(a));
        cyc(1'b1, 1'b1, 3'd3, 3'd0, 16'hBEEF);
        rd("write_read", 3'd3, 16'hBEEF);
        rd("neighbour", 3'd4, 16'h0004);
        rd("pre_diff", 3'd2, 16'h0002);
        cyc(1'b1, 1'b1, 3'd5, 3'd2, 16'h1234);
`ifndef DUAL_ADDR_REGMEM_OUT_REG_EN
        check("diff_addr_during", bus.dout, 16'h0002);
`endif
        rd("diff_addr_written", 3'd5, 16'h1234);
        rd("diff_addr_read", 3'd2, 16'h0002);
        rd("pre_collision", 3'd6, 16'h0006);
        cyc(1'b1, 1'b1, 3'd6, 3'd6, 16'hA5A5);
`ifndef DUAL_ADDR_REGMEM_OUT_REG_EN
        check("collision_before", bus.dout, 16'h0006);
`endif
        rd("collision_after", 3'd6, 16'hA5A5);
        cyc(1'b1, 1'b1, 3'd1, 3'd0, 16'hFFFF);
        rd("pre_reset_write", 3'd1, 16'hFFFF);
        cyc(1'b0, 1'b1, 3'd1, 3'd1, 16'h5555);
        rd("reset_priority", 3'd1, 16'h0001);
        rd("reset_restores", 3'd6, 16'h0006);
        repeat (4) cyc(1'b1, 1'b0, 3'd0, 3'd0, 16'hDEAD);
        rd("write_disabled", 3'd0, 16'h0000);
        for (int n = 0; n < 400; n++)
            cyc(1'($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'($urandom));
        @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/dual_addr_regmem.md
Name: dual_addr_regmem

Overview:
- Small register-file memory: 2^ADDR_W words of DATA_W bits.
- Independent write address (`waddr`) and read address (`addr`), so one write and one read can happen in the same cycle.
- Reset loads a fixed, known pattern, so readers see defined contents without any prior writes.
- Used as a scratch or lookup store inside datapaths.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 3, address width; depth = 2^ADDR_W (8 words by default).

Ports:
- clk  input  1  rising-edge clock; all state changes on this edge.
- reset  input  1  reset is synchronous and active-low. One clock; `reset` = 0 at a rising `clk` edge resets the block.
- we  input  1  write enable, active-high.
- waddr  input  ADDR_W  write address.
- addr  input  ADDR_W  read address.
- din  input  DATA_W  write data.
- dout  output  DATA_W  read data for `addr`.

Behaviour:
- Storage: array `mem[0 .. 2^ADDR_W-1]`, each DATA_W bits.
- Reset (`reset` = 0 sampled at a rising `clk` edge):
  - `mem[i]` <= i, zero-extended to DATA_W (default: 0x0000 .. 0x0007).
  - Reset has priority over `we`; no write occurs during a reset cycle.
- Before the first reset, contents are undefined (X in simulation).
- Write: on a rising edge with `reset` = 1 and `we` = 1, `mem[waddr]` <= `din`.
  - `we` = 0: contents unchanged.
- Read (default build, macro undefined):
  - Combinational: `dout` = `mem[addr]` at all times, zero cycles latency.
  - `dout` follows `addr` changes within the same cycle.
- Read/write to the same address in the same cycle:
  - Before the edge, `dout` shows the old value.
  - After the edge, `dout` shows `din` (read-after-write, visible with no extra latency).
- Read/write to different addresses: fully independent, no interaction.
- `dout` reset value: equals the reset contents of `mem[addr]` (0x0000 + `addr`) after the reset edge.
- All ADDR_W address values are valid; there is no out-of-range case and no wrap logic.
- `din` is ignored when `we` = 0.
- Reset mid-operation: a write presented on the reset edge is discarded; contents revert to the reset pattern.

Optional Feature:
- Macro: DUAL_ADDR_REGMEM_OUT_REG_EN.
- Defined:
  - `dout` is registered; on each rising edge `dout` <= `mem[addr]`, with `mem` taken before that edge's write. One-cycle read latency.
  - On a reset edge `dout` <= 0.
  - Same-address write and read in one cycle: `dout` returns the old data on that edge; the new data appears one edge later if `addr` is held.
- Undefined: the combinational read described in Behaviour.

Test Plan:
- Reset contents: hold `reset` = 0 for one edge, then `reset` = 1, `we` = 0; sweep `addr` 0..7 one per cycle -> `dout` = 0x0000, 0x0001, ..., 0x0007. With OUT_REG_EN, each value appears one cycle after its address.
- Write then read: `we` = 1, `waddr` = 3, `din` = 0xBEEF for one edge; then `we` = 0, `addr` = 3 -> `dout` = 0xBEEF; `addr` = 4 -> 0x0004 (neighbour untouched).
- Simultaneous different addresses: `we` = 1, `waddr` = 5, `din` = 0x1234, `addr` = 2 in the same cycle -> `dout` = 0x0002 throughout; next cycle `addr` = 5 -> 0x1234.
- Same-address collision: `addr` = 6, `waddr` = 6, `we` = 1, `din` = 0xA5A5 -> `dout` = 0x0006 before the edge, 0xA5A5 after. With OUT_REG_EN: 0x0006 on that edge, 0xA5A5 on the next.
- Reset priority: write 0xFFFF to address 1, then `reset` = 0 with `we` = 1, `waddr` = 1, `din` = 0x5555 -> after release, `addr` = 1 gives 0x0001.
- Write disabled: `we` = 0, `waddr` = 0, `din` = 0xDEAD for several edges -> `addr` = 0 still reads 0x0000.
